// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - register table, bus constants and state types for the WM8731 config sequencer
package wm8731_pkg;

   localparam int NUM_REGS = 11;
   localparam logic [7:0] DEV_WR_BYTE = 8'h34;

   // Element 0 is the codec reset; the last element sets ACTIVE.
   localparam logic [NUM_REGS-1:0][15:0] REG_TABLE = {
      16'h1201, 16'h1000, 16'h0E02, 16'h0C00, 16'h0A00, 16'h0812,
      16'h0679, 16'h0479, 16'h0217, 16'h0017, 16'h1E00
   };

   typedef enum logic [2:0] {
      S_IDLE, S_START_COND, S_BYTE, S_STOP_COND, S_FINISH, S_ABORT
   } seq_state_t;

   typedef enum logic [1:0] {
      OP_IDLE, OP_START, OP_STOP, OP_BYTE
   } phy_op_t;

   function automatic logic [7:0] dev_wr_byte(input logic [6:0] addr);
      return {addr, 1'b0};
   endfunction

   function automatic logic [7:0] table_byte(input logic [3:0] idx, input logic [1:0] sel,
                                             input logic [6:0] addr);
      logic [15:0] word;
      word = REG_TABLE[idx];
      case (sel)
         2'd0:    return dev_wr_byte(addr);
         2'd1:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/wm8731_cfg_seq_if.sv
// rtl/wm8731_cfg_seq_if.sv - control and 2-wire bus signals of the WM8731 config sequencer
interface wm8731_cfg_seq_if;
   logic       Start;
   logic       Busy;
   logic       Done;
   logic       AckErr;
   logic [3:0] RegIdx;
   logic       Scl;
   logic       SdaOut;
   logic       SdaIn;

   modport master (
      input  Start, SdaIn,
      output Busy, Done, AckErr, RegIdx, Scl, SdaOut
   );

   modport slave (
      output Start, SdaIn,
      input  Busy, Done, AckErr, RegIdx, Scl, SdaOut
   );
endinterface

// File: rtl/wm8731_i2c_phy.sv
// rtl/wm8731_i2c_phy.sv - quarter-bit timed START, STOP and byte+ACK primitives
module wm8731_i2c_phy
   import wm8731_pkg::*;
#(
   parameter int QTR = 125
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_byte,
   input  logic [7:0] cmd_data,
   output logic       cmd_done,
   output logic       nack,
   input  logic       sda_in,
   output logic       scl,
   output logic       sda_out
);

   localparam logic [11:0] QTR_LAST = 12'(QTR - 1);

   phy_op_t     op_q, op_d;
   logic [11:0] cnt_q, cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        nack_q, nack_d;
   logic        scl_q, scl_d;
   logic        sda_q, sda_d;
   logic        last_qtr;

   assign last_qtr = (cnt_q == QTR_LAST);
   // Asserted on the final cycle so a new command can start with no idle gap.
   assign cmd_done = (op_q != OP_IDLE) && last_qtr && (phase_q == 2'd3) &&
                     ((op_q != OP_BYTE) || (bit_q == 4'd8));

   always_comb begin
      op_d    = op_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      nack_d  = nack_q;
      if ((op_q == OP_IDLE) || cmd_done) begin
         cnt_d   = '0;
         phase_d = '0;
         bit_d   = '0;
         if (cmd_start) begin
            op_d = OP_START;
         end else if (cmd_stop) begin
            op_d = OP_STOP;
         end else if (cmd_byte) begin
            op_d    = OP_BYTE;
            shreg_d = cmd_data;
            nack_d  = 1'b0;
         end else begin
            op_d = OP_IDLE;
         end
      end else if (last_qtr) begin
         cnt_d   = '0;
         phase_d = phase_q + 2'd1;
         if (phase_q == 2'd3) begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[6:0], 1'b1};
         end
         if ((op_q == OP_BYTE) && (bit_q == 4'd8) && (phase_q == 2'd2)) begin
            nack_d = sda_in;
         end
      end else begin
         cnt_d = cnt_q + 12'd1;
      end

      scl_d = 1'b1;
      sda_d = 1'b1;
      case (op_d)
         OP_START: begin
            scl_d = (phase_d != 2'd3);
            sda_d = (phase_d < 2'd2);
         end
         OP_STOP: begin
            scl_d = (phase_d != 2'd0);
            sda_d = (phase_d >= 2'd2);
         end
         OP_BYTE: begin
            scl_d = phase_d[1];
            sda_d = (bit_d == 4'd8) ? 1'b1 : shreg_d[7];
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         op_q    <= OP_IDLE;
         cnt_q   <= '0;
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         nack_q  <= 1'b0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
      end else begin
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         nack_q  <= nack_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
      end
   end

   assign nack    = nack_q;
   assign scl     = scl_q;
   assign sda_out = sda_q;

endmodule

// File: rtl/wm8731_cfg_seq.sv
// rtl/wm8731_cfg_seq.sv - WM8731 power-up register sequencer: one 2-wire write per table entry
module wm8731_cfg_seq
   import wm8731_pkg::*;
#(
   parameter int         QTR      = 125,
   parameter logic [6:0] DEV_ADDR = 7'h1A
) (
   input logic             Clk,
   input logic             Rst,
   wm8731_cfg_seq_if.master bus
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   seq_state_t state_q, state_d;
   logic [3:0] reg_idx_q, reg_idx_d;
   logic [1:0] byte_idx_q, byte_idx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ack_err_q, ack_err_d;
   logic       abort_q, abort_d;
   logic       cmd_start, cmd_stop, cmd_byte;
   logic [7:0] cmd_data;
   logic       phy_done, phy_nack;

   always_comb begin
      state_d    = state_q;
      reg_idx_d  = reg_idx_q;
      byte_idx_d = byte_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ack_err_d  = ack_err_q;
      abort_d    = abort_q;
      cmd_start  = 1'b0;
      cmd_stop   = 1'b0;
      cmd_byte   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               state_d   = S_START_COND;
               busy_d    = 1'b1;
               ack_err_d = 1'b0;
               abort_d   = 1'b0;
               reg_idx_d = '0;
               cmd_start = 1'b1;
            end
         end
         S_START_COND: begin
            if (phy_done) begin
               state_d    = S_BYTE;
               byte_idx_d = 2'd0;
               cmd_byte   = 1'b1;
            end
         end
         S_BYTE: begin
            if (phy_done) begin
               if (phy_nack) begin
                  state_d   = S_STOP_COND;
                  abort_d   = 1'b1;
                  ack_err_d = 1'b1;
                  cmd_stop  = 1'b1;
               end else if (byte_idx_q == 2'd2) begin
                  state_d  = S_STOP_COND;
                  cmd_stop = 1'b1;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  cmd_byte   = 1'b1;
               end
            end
         end
         S_STOP_COND: begin
            if (phy_done) begin
               if (abort_q) begin
                  state_d = S_ABORT;
                  done_d  = 1'b1;
               end else if (reg_idx_q < LAST_IDX) begin
                  state_d   = S_START_COND;
                  reg_idx_d = reg_idx_q + 4'd1;
                  cmd_start = 1'b1;
               end else begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end
            end
         end
         // Busy stays high through the Done cycle; Start here is not sampled.
         S_FINISH, S_ABORT: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      cmd_data = table_byte(reg_idx_d, byte_idx_d, DEV_ADDR);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         reg_idx_q  <= '0;
         byte_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         reg_idx_q  <= reg_idx_d;
         byte_idx_q <= byte_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
         abort_q    <= abort_d;
      end
   end

   wm8731_i2c_phy #(.QTR(QTR)) u_phy (
      .Clk       (Clk),
      .Rst       (Rst),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .cmd_byte  (cmd_byte),
      .cmd_data  (cmd_data),
      .cmd_done  (phy_done),
      .nack      (phy_nack),
      .sda_in    (bus.SdaIn),
      .scl       (bus.Scl),
      .sda_out   (bus.SdaOut)
   );

   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.AckErr = ack_err_q;
   assign bus.RegIdx = reg_idx_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// tb/tb_wm8731_cfg_seq.sv - directed bench for wm8731_cfg_seq with a 2-wire slave/decoder model
module tb_wm8731_cfg_seq;

   localparam int Q       = 4;
   localparam int TXN_CYC = 116 * Q;
   localparam int RUN_CYC = 11 * TXN_CYC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   wm8731_cfg_seq_if bus_a();
   wm8731_cfg_seq_if bus_b();

   wm8731_cfg_seq #(.QTR(Q), .DEV_ADDR(7'h1A)) dut_a (.Clk(clk), .Rst(rst), .bus(bus_a));
   wm8731_cfg_seq #(.QTR(Q), .DEV_ADDR(7'h1B)) dut_b (.Clk(clk), .Rst(rst), .bus(bus_b));

   logic [15:0] ref_tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                                 16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

   logic       pscl [2]     = '{1'b1, 1'b1};
   logic       psda [2]     = '{1'b1, 1'b1};
   logic       sda_in [2]   = '{1'b1, 1'b1};
   logic       ack_hold [2] = '{1'b0, 1'b0};
   logic       ack_val [2]  = '{1'b0, 1'b0};
   logic [7:0] shreg [2]    = '{8'h00, 8'h00};
   int bit_cnt [2]     = '{0, 0};
   int byte_in_txn [2] = '{0, 0};
   int nstart [2]      = '{0, 0};
   int nstop [2]       = '{0, 0};
   int ndone [2]       = '{0, 0};
   int high8 [2]       = '{0, 0};
   int viol [2]        = '{0, 0};
   int run_len [2]     = '{0, 0};
   int nbytes [2]      = '{0, 0};
   logic [7:0] blog [2][512];
   logic m_scl, m_sda;
   int nack_base = 0;
   int nack_txn  = -1;
   int nack_byte = 0;

   assign bus_a.SdaIn = sda_in[0];
   assign bus_b.SdaIn = sda_in[1];

   // Slave model and bus decoder for both instances; only instance 0 can be told to NACK.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         m_scl = (g == 0) ? bus_a.Scl : bus_b.Scl;
         m_sda = (g == 0) ? bus_a.SdaOut : bus_b.SdaOut;
         if ((g == 0) ? bus_a.Done : bus_b.Done) ndone[g]++;
         if (rst) begin
            bit_cnt[g]  = 0;
            ack_hold[g] = 1'b0;
         end else begin
            if (m_scl && pscl[g] && psda[g] && !m_sda) begin
               nstart[g]++;
               bit_cnt[g]     = 0;
               byte_in_txn[g] = 0;
            end
            if (m_scl && pscl[g] && !psda[g] && m_sda) nstop[g]++;
            if (m_scl && !pscl[g] && (m_sda != psda[g])) viol[g]++;
            if (m_scl && !pscl[g]) begin
               if (bit_cnt[g] < 8) begin
                  shreg[g] = {shreg[g][6:0], m_sda};
                  bit_cnt[g]++;
                  if (bit_cnt[g] == 8)
                     ack_val[g] = (g == 0) && (nstart[g] - nack_base - 1 == nack_txn) &&
                                  (byte_in_txn[g] == nack_byte);
               end else begin
                  if (nbytes[g] < 512) blog[g][nbytes[g]] = shreg[g];
                  nbytes[g]++;
                  byte_in_txn[g]++;
                  bit_cnt[g]  = 0;
                  ack_hold[g] = 1'b1;
               end
            end
            if (!m_scl && pscl[g]) begin
               ack_hold[g] = 1'b0;
               if (run_len[g] == 8) high8[g]++;
            end
         end
         run_len[g] = m_scl ? run_len[g] + 1 : 0;
         pscl[g]    = m_scl;
         psda[g]    = m_sda;
         sda_in[g]  = (bit_cnt[g] == 8 || ack_hold[g]) ? ack_val[g] : 1'b1;
      end
   end

   typedef struct {
      int   mode;       // 0 plain, 2 Start during entry 5, 3 Start in the Done cycle
      int   nack_txn;
      int   nack_byte;
      int   exp_bytes;
      int   exp_done;
      logic exp_err;
      int   exp_idx;
      int   exp_starts;
   } vec_t;

   vec_t vecs [3];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int exp_byte(input int i, input int dev);
      logic [15:0] w;
      w = ref_tbl[i / 3];
      case (i % 3)
         0:       return dev;
         1:       return int'(w[15:8]);
         default: return int'(w[7:0]);
      endcase
   endfunction

   task automatic wait_done_a(output bit got);
      got = 1'b0;
      for (int i = 0; i < RUN_CYC + 200 && !got; i++) begin
         @(negedge clk);
         got = bus_a.Done;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int t0, b0, s0, p0, d0, h0, x0;
      bit got;
      b0 = nbytes[0]; s0 = nstart[0]; p0 = nstop[0];
      d0 = ndone[0];  h0 = high8[0];  x0 = viol[0];
      nack_txn  = v.nack_txn;
      nack_byte = v.nack_byte;
      @(negedge clk);
      nack_base   = nstart[0];
      bus_a.Start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus_a.Start = 1'b0;
      check("busy_after_start", int'(bus_a.Busy), 1);
      check("ackerr_cleared", int'(bus_a.AckErr), 0);
      check("regidx_at_start", int'(bus_a.RegIdx), 0);
      if (v.mode == 2) begin
         fork
            begin
               repeat (5 * TXN_CYC + 100) @(negedge clk);
               bus_a.Start = 1'b1;
               @(negedge clk);
               bus_a.Start = 1'b0;
            end
         join_none
      end
      wait_done_a(got);
      check("done_seen", int'(got), 1);
      check("done_cycle", cyc - t0, v.exp_done);
      check("busy_in_done", int'(bus_a.Busy), 1);
      check("ackerr_at_done", int'(bus_a.AckErr), int'(v.exp_err));
      check("regidx_at_done", int'(bus_a.RegIdx), v.exp_idx);
      if (v.mode == 3) bus_a.Start = 1'b1;
      @(negedge clk);
      bus_a.Start = 1'b0;
      check("busy_after_done", int'(bus_a.Busy), 0);
      check("done_one_cycle", int'(bus_a.Done), 0);
      check("ackerr_sticky", int'(bus_a.AckErr), int'(v.exp_err));
      repeat (40) @(negedge clk);
      check("still_idle", int'(bus_a.Busy), 0);
      check("start_count", nstart[0] - s0, v.exp_starts);
      check("stop_count", nstop[0] - p0, v.exp_starts);
      check("done_pulses", ndone[0] - d0, 1);
      check("byte_count", nbytes[0] - b0, v.exp_bytes);
      check("scl_high8_count", high8[0] - h0, v.exp_bytes * 9);
      check("sda_on_scl_rise", viol[0] - x0, 0);
      for (int i = 0; i < v.exp_bytes; i++)
         check($sformatf("byte_a[%0d]", i), int'(blog[0][b0 + i]), exp_byte(i, 'h34));
   endtask

   initial begin
      int  t0, b0, s0, p0, d0;
      bit  got;
      vecs[0] = '{3, -1, 0, 33, RUN_CYC, 1'b0, 10, 11};
      vecs[1] = '{0,  3, 1, 11, (3 * 116 + 80) * Q, 1'b1, 3, 4};
      vecs[2] = '{2, -1, 0, 33, RUN_CYC, 1'b0, 10, 11};

      bus_a.Start = 1'b0;
      bus_b.Start = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_scl", int'(bus_a.Scl), 1);
      check("rst_sda", int'(bus_a.SdaOut), 1);
      check("rst_busy", int'(bus_a.Busy), 0);
      check("rst_done", int'(bus_a.Done), 0);
      check("rst_ackerr", int'(bus_a.AckErr), 0);
      check("rst_regidx", int'(bus_a.RegIdx), 0);
      check("rst_scl_b", int'(bus_b.Scl), 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int v = 0; v < 3; v++) run_vec(vecs[v]);

      // Reset during Q2 of bit 2 of the device byte in entry 7.
      nack_txn = -1;
      @(negedge clk);
      bus_a.Start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus_a.Start = 1'b0;
      while (cyc - t0 < 7 * TXN_CYC + 4 * Q + 2 * 4 * Q + 2 * Q + 1) @(negedge clk);
      check("pre_rst_scl_high", int'(bus_a.Scl), 1);
      check("pre_rst_busy", int'(bus_a.Busy), 1);
      check("pre_rst_regidx", int'(bus_a.RegIdx), 7);
      s0 = nstart[0]; p0 = nstop[0]; d0 = ndone[0];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_scl", int'(bus_a.Scl), 1);
      check("midrst_sda", int'(bus_a.SdaOut), 1);
      check("midrst_busy", int'(bus_a.Busy), 0);
      check("midrst_done", int'(bus_a.Done), 0);
      check("midrst_regidx", int'(bus_a.RegIdx), 0);
      repeat (60) @(negedge clk);
      check("midrst_no_done", ndone[0] - d0, 0);
      check("midrst_no_stop", nstop[0] - p0, 0);
      check("midrst_no_start", nstart[0] - s0, 0);
      run_vec('{0, -1, 0, 33, RUN_CYC, 1'b0, 10, 11});

      // Alternate device address on the second instance.
      b0 = nbytes[1];
      @(negedge clk);
      bus_b.Start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus_b.Start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < RUN_CYC + 200 && !got; i++) begin
         @(negedge clk);
         got = bus_b.Done;
      end
      check("b_done_seen", int'(got), 1);
      check("b_done_cycle", cyc - t0, RUN_CYC);
      check("b_ackerr", int'(bus_b.AckErr), 0);
      repeat (10) @(negedge clk);
      check("b_byte_count", nbytes[1] - b0, 33);
      for (int i = 0; i < 33; i++)
         check($sformatf("byte_b[%0d]", i), int'(blog[1][b0 + i]), exp_byte(i, 'h36));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
